t2s_arbiter: RTL

T2S_ARBITER -- requirements
Module: t2s_arbiter

---
 rtl/t2s_arbiter_if.sv | 28 ++
 rtl/t2s_arbiter.sv | 75 +++++++
 2 files changed

// File: rtl/t2s_arbiter_if.sv
// Requester/output bundle of the round-robin two's-complement to sign-magnitude arbiter.
// The arbiter takes the slave side; requesters and the downstream sink take the master side.
interface t2s_arbiter_if #(
    parameter int DATA_WIDTH = 6,
    parameter int NUM_REQ    = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                          en;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH:0]           out_data;
    logic [ID_W-1:0]               out_id;
    logic [15:0]                   neg_count;

    modport master (
        output en, req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id, neg_count
    );

    modport slave (
        input  en, req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id, neg_count
    );
endinterface

// File: rtl/t2s_arbiter.sv
// Round-robin arbiter feeding a single two's-complement to sign-magnitude converter
// with a one-entry output register that sustains one word per cycle.
module t2s_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int NUM_REQ    = 4
) (
    input logic           clk,
    input logic           rst_n,
    t2s_arbiter_if.slave  bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       gnt_idx;
    logic [ID_W-1:0]       cand;
    logic                  gnt_any;
    logic                  free;
    logic                  take;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] mag;
    logic                  sign;

    logic                  out_valid_r;
    logic [DATA_WIDTH:0]   out_data_r;
    logic [ID_W-1:0]       out_id_r;
    logic [15:0]           neg_count_r;

    // First valid requester at or after rr_ptr, wrapping; depends only on req_valid and rr_ptr.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_any && bus.req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign free = !out_valid_r || bus.out_ready;
    assign take = rst_n && bus.en && free && gnt_any;

    assign bus.req_ready = take ? (NUM_REQ'(1) << gnt_idx) : '0;

    // Negation of the most-negative word wraps back to itself, which is exactly its magnitude.
    assign word = bus.req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign sign = word[DATA_WIDTH-1];
    assign mag  = sign ? (~word + 1'b1) : word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_id_r    <= '0;
            rr_ptr      <= '0;
            neg_count_r <= '0;
        end else if (take) begin
            out_valid_r <= 1'b1;
            out_data_r  <= {sign, mag};
            out_id_r    <= gnt_idx;
            rr_ptr      <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
            if (sign && neg_count_r != 16'hFFFF)
                neg_count_r <= neg_count_r + 16'd1;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_id    = out_id_r;
    assign bus.neg_count = neg_count_r;
endmodule
